// File: rtl/imem_loadable.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imem_loadable: synchronous-read instruction memory with a streamed program  |
// | load port, byte-addressed fetch with stall hold and fault flags.            |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module imem_loadable #(
  parameter int                      INSTR_LENGTH = 32,
  parameter int                      MEM_DEPTH    = 64,
  parameter int                      PC_WIDTH     = 32,
  parameter logic [INSTR_LENGTH-1:0] NOP_WORD     = 32'h00000013
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fetch_req,
  input  logic [PC_WIDTH-1:0]     fetch_addr,
  input  logic                    fetch_stall,
  output logic [INSTR_LENGTH-1:0] instr,
  output logic                    instr_valid,
  output logic                    fault_misaligned,
  output logic                    fault_oob,
  input  logic                    load_start,
  input  logic                    load_valid,
  input  logic [INSTR_LENGTH-1:0] load_data,
  input  logic                    load_last,
  output logic                    load_ready,
  output logic                    mem_busy,
  output logic                    load_overflow
);

  localparam int AW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  // Where the instr output is sourced from; ZERO only until the first fetch.
  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_NOP  = 2'd1,
    SRC_RAM  = 2'd2
  } src_t;

  state_t                  state_q, state_d;
  logic [AW:0]             ptr_q, ptr_d;
  logic                    overflow_q, overflow_d;
  logic                    valid_q, valid_d;
  logic                    fmis_q, fmis_d;
  logic                    foob_q, foob_d;
  src_t                    src_q, src_d;

  logic [INSTR_LENGTH-1:0] mem [MEM_DEPTH];
  logic [INSTR_LENGTH-1:0] rd_q;

  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic [INSTR_LENGTH-1:0] wr_data;
  logic                    fetch_go;
  logic                    addr_mis;
  logic                    addr_oob;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    wr_addr    = ptr_q[AW-1:0];
    wr_data    = NOP_WORD;
    load_ready = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        wr_en = 1'b1;
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == (AW+1)'(MEM_DEPTH - 1)) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end
      end
      ST_IDLE: begin
        if (load_start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
        end
      end
      ST_LOAD: begin
        // ptr_q[AW] set means every entry has been written this load.
        if (!ptr_q[AW]) begin
          load_ready = 1'b1;
          if (load_valid) begin
            wr_en   = 1'b1;
            wr_data = load_data;
            ptr_d   = ptr_q + 1'b1;
            if (load_last) state_d = ST_IDLE;
          end
        end else if (load_valid) begin
          if (load_last) state_d = ST_IDLE;
          else           overflow_d = 1'b1;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    fetch_go = fetch_req && !fetch_stall && (state_q == ST_IDLE);
    addr_mis = |fetch_addr[1:0];
    addr_oob = fetch_addr[PC_WIDTH-1:2] >= (PC_WIDTH-2)'(MEM_DEPTH);
    valid_d  = valid_q;
    fmis_d   = fmis_q;
    foob_d   = foob_q;
    src_d    = src_q;
    if (!fetch_stall) begin
      valid_d = fetch_go;
      fmis_d  = fetch_go && addr_mis;
      foob_d  = fetch_go && addr_oob;
      if (fetch_go) src_d = (addr_mis || addr_oob) ? SRC_NOP : SRC_RAM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      ptr_q      <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      fmis_q     <= 1'b0;
      foob_q     <= 1'b0;
      src_q      <= SRC_ZERO;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
      fmis_q     <= fmis_d;
      foob_q     <= foob_d;
      src_q      <= src_d;
    end
  end

  // Array and read register carry no reset so they map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_addr] <= wr_data;
    if (fetch_go)      rd_q <= mem[fetch_addr[AW+1:2]];
  end

  always_comb begin
    unique case (src_q)
      SRC_ZERO: instr = '0;
      SRC_NOP:  instr = NOP_WORD;
      default:  instr = rd_q;
    endcase
  end

  assign instr_valid      = valid_q;
  assign fault_misaligned = fmis_q;
  assign fault_oob        = foob_q;
  assign mem_busy         = (state_q != ST_IDLE);
  assign load_overflow    = overflow_q;

endmodule
`default_nettype wire

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
Parametrised successor to the fixed 32-entry instruction ROM. It is a synchronous-read instruction memory with:
- a byte-addressed fetch port with stall support and fault flags;
- a streamed program-load port driven by a small FSM.

It sits between the PC/fetch stage and the decode stage. Programs are loaded at run time instead of being baked into an initial block.

Parameters:
INSTR_LENGTH, 32, instruction word width in bits; only 32 is supported.
MEM_DEPTH, 64, number of instruction words; a power of two, at least 4.
PC_WIDTH, 32, width of the byte-address fetch PC.
NOP_WORD, 32'h00000013, fill value (ADDI x0,x0,0) used after clear and for faulted fetches.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
fetch_req  input  1  fetch request for this cycle
fetch_addr  input  PC_WIDTH  byte PC of requested instruction
fetch_stall  input  1  pipeline stall; hold fetch output registers
instr  output  INSTR_LENGTH  fetched instruction
instr_valid  output  1  instr holds a fetch response
fault_misaligned  output  1  response is for a PC with [1:0] != 0
fault_oob  output  1  response is for a word index >= MEM_DEPTH
load_start  input  1  pulse: begin program load at word 0
load_valid  input  1  load_data valid
load_data  input  INSTR_LENGTH  program word
load_last  input  1  qualifies the final word of the load
load_ready  output  1  load word accepted when load_valid && load_ready
mem_busy  output  1  memory in CLEAR or LOAD; fetches not served
load_overflow  output  1  sticky: words were offered after the memory filled

Behaviour:
- Reset: instr=0, instr_valid=0, both faults=0, load_ready=0, load_overflow=0, mem_busy=1. The FSM enters CLEAR.
- FSM states: CLEAR, IDLE, LOAD.
- CLEAR:
  - Writes NOP_WORD to one index per cycle, 0..MEM_DEPTH-1, so it lasts exactly MEM_DEPTH cycles.
  - Goes to IDLE after the last write. load_start is ignored while in CLEAR.
- IDLE:
  - mem_busy=0 and fetches are served.
  - load_start goes to LOAD and sets the write pointer to 0. load_overflow is not cleared by this.
- LOAD:
  - mem_busy=1. load_ready=1 while the write pointer < MEM_DEPTH.
  - Each accepted word is written at the pointer, and the pointer then increments.
  - An accepted word with load_last=1 returns the FSM to IDLE on the next cycle.
  - When the pointer reaches MEM_DEPTH, load_ready=0. If load_valid is then seen without load_last, load_overflow is set. The FSM returns to IDLE when load_valid && load_last occurs, with the data discarded.
  - Unwritten entries keep their previous contents.
  - load_start while in LOAD is ignored.
- Fetch, 1-cycle latency:
  - If in IDLE with fetch_req=1 and fetch_stall=0 at edge N, the response appears after edge N+1 and instr_valid=1.
  - Word index = fetch_addr[$clog2(MEM_DEPTH)+1:2].
  - If fetch_addr[1:0] != 0: instr=NOP_WORD, fault_misaligned=1.
  - Else if fetch_addr[PC_WIDTH-1:2] >= MEM_DEPTH: instr=NOP_WORD, fault_oob=1.
  - Both faults can be set together; when they are, instr=NOP_WORD.
  - Otherwise instr = mem[index] and both faults are 0.
- fetch_stall=1: instr, instr_valid and the fault flags hold their values, regardless of fetch_req. Stall takes priority.
- fetch_req=0 with fetch_stall=0: instr_valid=0 next cycle, and instr holds its last value.
- fetch_req while mem_busy=1 (and no stall): instr_valid=0 next cycle, faults=0, and the request is dropped.
- Read-during-write cannot occur, because fetch and load are mutually exclusive by FSM state.
- rst mid-LOAD or mid-CLEAR: the next state is CLEAR, restarting from index 0. Memory contents are refilled with NOP. load_overflow is cleared.
- The memory must infer block/distributed RAM: one write port and one synchronous read port, with no reset on the array.

Test Plan:
- Reset, wait MEM_DEPTH cycles; mem_busy falls at cycle MEM_DEPTH. Fetch 0x0, 0x4, 0xFC → instr=32'h00000013 with valid=1 one cycle after each request.
- load_start, then stream 32'h00100213, 32'h00200293, 32'h005201B3 (last=1). Then fetch 0x4 → instr=32'h00200293 after 1 cycle; fetch 0xC → 32'h00000013.
- Fetch 0x2 → NOP, fault_misaligned=1. Fetch 0x100 (MEM_DEPTH=64) → NOP, fault_oob=1. Fetch 0x102 → NOP, both faults=1.
- Fetch 0x8, then hold fetch_stall=1 for 3 cycles while fetch_addr=0x0 → instr stays 32'h005201B3 with valid=1; after the stall drops, instr=32'h00100213.
- Load MEM_DEPTH words without last, then offer one more with last=0 → load_ready=0 and load_overflow=1. Then offer a word with last=1 → FSM returns to IDLE; word 63 holds the 64th data word.
- Assert rst on the 2nd load beat → mem_busy stays 1 for MEM_DEPTH cycles, then fetch 0x0 returns 32'h00000013.
